// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   XLEN       - datapath / PC width
//   INSTR_NOP  - word presented on the ins bus while the queue is empty
//   PC_STEP    - sequential PC increment
//   fetch_state_t  - RUN (issuing) / DRAIN (discarding stale responses)
//   fetch_entry_t  - one queue entry: {pc, instr}
package fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h00000013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [0:0] {
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous in-order queue with flush.
//   clk, rst            - clock, asynchronous active-low reset
//   push, push_data     - write one entry (ignored when full without a pop)
//   pop                 - remove the head entry (ignored when empty)
//   flush               - discard all entries; wins over push and pop
//   count               - number of valid entries (0..DEPTH)
//   head                - oldest entry, valid only while count != 0
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A pop frees the slot the push lands in, so full+pop+push is legal.
        do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: head is only meaningful while count != 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential-PC fetch stage with an instruction queue and redirect.
//   clk, rst                      - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     - fetch request to instruction memory
//   imem_rsp_valid/data           - in-order responses, one per accepted request
//   redirect_valid/pc             - one-cycle branch/jump strobe; pc[1:0] ignored
//   ins_valid/ins/ins_pc/ins_ready- queue head toward decode (NOP / pc 0 when empty)
//   stall_cnt, flush_cnt          - only when FETCH_PERF_CNT_EN is defined
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_tag_q, pc_tag_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          req_en_q;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic          req_fire;
    logic [CW:0]   inflight;
    logic [31:0]   redirect_target;
    logic          unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Queued plus in-flight words; requests stop once this fills the queue.
    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_q};

    // req_en_q holds requests off while reset is asserted.
    assign imem_req_valid = req_en_q && (state_q == RUN) &&
                            (inflight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign ins_valid = (fifo_count != '0);
    assign ins       = ins_valid ? fifo_head.instr : INSTR_NOP;
    assign ins_pc    = ins_valid ? fifo_head.pc : '0;

    always_comb begin
        req_fire      = imem_req_valid && imem_req_ready;
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_tag_d      = pc_tag_q;
        drop_d        = drop_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        fifo_pop      = ins_valid && ins_ready;
        push_entry    = '{pc: pc_tag_q, instr: imem_rsp_data};
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;

        if (redirect_valid) begin
            // Everything still in flight (incl. this cycle's accept) becomes stale.
            fetch_pc_d = redirect_target;
            pc_tag_d   = redirect_target;
            fifo_flush = 1'b1;
            fifo_pop   = 1'b0;
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (imem_rsp_valid) begin
                        fifo_push = 1'b1;
                        pc_tag_d  = pc_tag_q + PC_STEP;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) drop_d = drop_q - CW'(1);
                    if (drop_d == '0) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            pc_tag_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            req_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_tag_q      <= pc_tag_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_en_q      <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] stall_sum;
    logic [32:0] flush_sum;

    always_comb begin
        stall_sum = {1'b0, stall_cnt} + 33'(ins_ready && !ins_valid);
        flush_sum = {1'b0, flush_cnt} + 33'(inflight);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
            if (redirect_valid) flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

    // Credit accounting reserves a slot for every accepted request.
    assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && !redirect_valid && (state_q == RUN) &&
          (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int          n_tests;
    int          n_fail;
    int          n_acc;
    int          mem_lat;
    logic        pv [3];
    logic [31:0] pa [3];

    instr_fetch_unit #(
        .RESET_PC   (32'h00000000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00008133;
            32'h4:   return 32'h400081B3;
            32'h8:   return 32'h00009133;
            default: return 32'hA5000000 | a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample this cycle's handshake, advance the memory pipeline.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        #1;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        if (fire) n_acc++;
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = fire;
        pa[0] = a;
        imem_rsp_valid = pv[mem_lat-1];
        imem_rsp_data  = imem_rsp_valid ? mem_word(pa[mem_lat-1]) : 32'h0;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ins_ready      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pa[i] = 32'h0;
        end
    endtask

    // Leaves the bench in the first cycle with requests enabled.
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_acc = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_acc   = 0;
        mem_lat = 1;
        rst     = 1'b0;
        clear_inputs();
        #3;
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("rst_ins", ins, 32'h00000013);
        check("rst_ins_pc", ins_pc, 32'h0);

        // Streaming with a 1-cycle memory
        do_reset();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        check("s1_c0_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s1_c0_addr", imem_req_addr, 32'h0);
        tick();
        check("s1_c1_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("s1_c1_addr", imem_req_addr, 32'h4);
        tick();
        check("s1_c2_ins_valid", {31'h0, ins_valid}, 32'h1);
        check("s1_c2_ins", ins, 32'h00008133);
        check("s1_c2_ins_pc", ins_pc, 32'h0);
        tick();
        check("s1_c3_ins", ins, 32'h400081B3);
        check("s1_c3_ins_pc", ins_pc, 32'h4);
        tick();
        check("s1_c4_ins", ins, 32'h00009133);
        check("s1_c4_ins_pc", ins_pc, 32'h8);

        // Backpressure: consumer stalled, queue fills to 4
        do_reset();
        imem_req_ready = 1'b1;
        repeat (8) tick();
        check("s2_acc_count", 32'(n_acc), 32'd4);
        check("s2_req_valid_full", {31'h0, imem_req_valid}, 32'h0);
        check("s2_addr_full", imem_req_addr, 32'h10);
        check("s2_head_valid", {31'h0, ins_valid}, 32'h1);
        ins_ready = 1'b1;
        check("s2_r0_ins_pc", ins_pc, 32'h0);
        tick();
        check("s2_r1_ins_pc", ins_pc, 32'h4);
        check("s2_r1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s2_r1_addr", imem_req_addr, 32'h10);
        tick();
        check("s2_r2_ins_pc", ins_pc, 32'h8);
        tick();
        check("s2_r3_ins_pc", ins_pc, 32'hC);
        tick();
        check("s2_r4_ins_pc", ins_pc, 32'h10);
        check("s2_r4_ins", ins, 32'hA5000010);

        // Redirect with two requests outstanding (3-cycle memory)
        mem_lat = 3;
        do_reset();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        tick();
        check("s3_c1_addr", imem_req_addr, 32'h4);
        tick();
        imem_req_ready = 1'b0;
        check("s3_c2_rsp_idle", {31'h0, imem_rsp_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000103;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("s3_c3_req_valid_drain", {31'h0, imem_req_valid}, 32'h0);
        check("s3_c3_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("s3_c3_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check("s3_flush_cnt", flush_cnt, 32'd2);
`endif
        tick();
        check("s3_c4_req_valid_drain", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("s3_c5_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s3_c5_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check("s3_stall_cnt", stall_cnt, 32'd5);
`endif
        repeat (3) tick();
        check("s3_c8_ins_valid", {31'h0, ins_valid}, 32'h0);
        tick();
        check("s3_c9_ins_valid", {31'h0, ins_valid}, 32'h1);
        check("s3_c9_ins_pc", ins_pc, 32'h100);
        check("s3_c9_ins", ins, 32'hA5000100);

        // Redirect coinciding with a response and a pop
        mem_lat = 1;
        do_reset();
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        repeat (2) tick();
        check("s4_c2_ins_pc", ins_pc, 32'h0);
        check("s4_c2_rsp", {31'h0, imem_rsp_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000200;
        tick();
        redirect_valid = 1'b0;
        check("s4_c3_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("s4_c3_ins", ins, 32'h00000013);
        check("s4_c3_ins_pc", ins_pc, 32'h0);
        check("s4_c3_req_valid", {31'h0, imem_req_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("s4_flush_cnt", flush_cnt, 32'd2);
`endif
        tick();
        check("s4_c4_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s4_c4_addr", imem_req_addr, 32'h200);
        repeat (2) tick();
        check("s4_c6_ins_pc", ins_pc, 32'h200);
        check("s4_c6_ins", ins, 32'hA5000200);

        // PC wrap at the top of the address space
        do_reset();
        ins_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFF8;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("s5_c1_addr", imem_req_addr, 32'hFFFFFFF8);
        tick();
        check("s5_c2_addr", imem_req_addr, 32'hFFFFFFFC);
        tick();
        check("s5_c3_addr", imem_req_addr, 32'h0);
        check("s5_c3_ins_pc", ins_pc, 32'hFFFFFFF8);
        tick();
        check("s5_c4_ins_pc", ins_pc, 32'hFFFFFFFC);
        tick();
        check("s5_c5_ins_pc", ins_pc, 32'h0);
        check("s5_c5_ins", ins, 32'h00008133);

        // Asynchronous reset in the middle of a cycle
        #3;
        rst = 1'b0;
        #1;
        check("s6_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("s6_addr", imem_req_addr, 32'h0);
        check("s6_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("s6_ins", ins, 32'h00000013);
        check("s6_ins_pc", ins_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("s6_stall_cnt", stall_cnt, 32'h0);
        check("s6_flush_cnt", flush_cnt, 32'h0);
`endif
        do_reset();
        check("s6_restart_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("s6_restart_addr", imem_req_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the 32-bit processor.
- Generates sequential PCs and issues requests to the instruction memory over a valid/ready handshake.
- Buffers the returned words in a small in-order queue and presents them to the decode/execute stage on the `ins` bus with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all fetched and in-flight work.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- FIFO_DEPTH, 4, instruction queue entries (power of two, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous, active-low. Asserting it clears all state immediately; release is synchronised externally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order, one per request.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 00).
- ins_valid  out  1  head of queue valid.
- ins  out  32  instruction at head; 32'h00000013 (NOP) when queue empty.
- ins_pc  out  32  PC of head instruction; 0 when empty.
- ins_ready  in  1  consumer takes head this cycle.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop = 0; state = RUN.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - ins_valid = 0, ins = NOP, ins_pc = 0.
- States:
  - RUN: issue requests.
  - DRAIN: stale in-flight responses are being discarded; no new requests.
- Request issue in RUN:
  - imem_req_valid = 1 while count + outstanding < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (mod 2^32, so 0xFFFFFFFC wraps to 0) and outstanding++.
- Response in RUN:
  - Push {data, pc}; outstanding--.
  - The request PC is tracked by a pc_tag register advanced per accepted response.
  - The credit rule guarantees no overflow. A response arriving with the queue full is an assertion failure.
- Consumer side:
  - Head is registered.
  - ins_valid&&ins_ready pops one entry.
  - Push and pop in the same cycle keep count unchanged.
  - A response into an empty queue appears on `ins` the next cycle, so minimum fetch latency is 2 cycles from request acceptance, with a 1-cycle memory.
- Redirect (highest priority):
  - Queue cleared; fetch_pc = pc_tag = {redirect_pc[31:2], 2'b00}.
  - drop = outstanding (counting any request accepted in the same cycle).
  - Next state = DRAIN if drop != 0, else RUN.
  - ins_valid falls the next cycle; a same-cycle pop is ignored.
  - A same-cycle response is discarded and decrements drop.
  - A pending unaccepted request is withdrawn: valid may drop without ready. This is the sole permitted handshake exception.
- DRAIN:
  - imem_req_valid = 0.
  - Each response decrements drop and outstanding, and its data is discarded.
  - When drop reaches 0, go to RUN the next cycle.
  - A redirect in DRAIN reloads the PC and keeps draining the remaining count.
- Reset mid-operation: all state is cleared asynchronously; in-flight memory responses after reset are the memory's responsibility to squash.
- Widths:
  - Counters are $clog2(FIFO_DEPTH)+1 bits.
  - PC arithmetic is 32-bit unsigned, overflow discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle ins_ready=1 && ins_valid=0.
  - flush_cnt increments by (count + outstanding) on each redirect.
  - Both saturate at 32'hFFFFFFFF; reset to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32, INSTR_NOP = 32'h00000013, PC_STEP = 4.
  - fetch_state_t enum {RUN, DRAIN}.
  - Entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo:
  - Synchronous FIFO, parameterised depth/width.
  - push, pop, flush, count, head outputs.
  - Flush has priority over push.

Test Plan:
- Reset with RESET_PC=0, memory always ready with 1-cycle latency returning 0x00008133, 0x400081B3, 0x00009133, ... -> ins presents them in order with ins_pc 0,4,8; first ins_valid 2 cycles after first acceptance.
- ins_ready held 0 -> exactly 4 requests accepted (0x0..0xC), then imem_req_valid=0. Release ins_ready -> 4 pops, fetch resumes at 0x10.
- Redirect to 0x103 with 2 requests outstanding -> queue cleared, DRAIN, 2 responses discarded, next request addr 0x100, first ins_pc 0x100.
- Redirect in the same cycle as a response and a pop -> response dropped, no pop counted, ins_valid=0 next cycle, following PC = redirect target.
- Redirect to 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Async reset asserted mid-stream, off a clock edge -> outputs return to reset values immediately. With FETCH_PERF_CNT_EN defined: stall_cnt and flush_cnt read 0 after reset and match the expected counts in the redirect scenario (flush_cnt = 2).
